// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM. It decodes the latched IR fields into registered datapath selects and strobes.
// Optional feature macro: OVERFLOW_EXC_EN adds the EXC trap state for overflow and undefined instructions.
module mc_control_unit #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Zero,
    input  logic       Overflow,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       ABWrite,
    output logic       ALUOutWrite,
    output logic       MDRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       EPCWrite,
    output logic       BranchNE,
    output logic [4:0] state_dbg
);

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH     = 5'd1,
        S_DECODE    = 5'd2,
        S_R_EXEC    = 5'd3,
        S_R_WB      = 5'd4,
        S_ADDI_EXEC = 5'd5,
        S_I_WB      = 5'd6,
        S_MEM_ADDR  = 5'd7,
        S_MEM_READ  = 5'd8,
        S_MEM_WB    = 5'd9,
        S_MEM_WRITE = 5'd10,
        S_BRANCH    = 5'd11,
        S_JUMP      = 5'd12,
        S_JR        = 5'd13
`ifdef OVERFLOW_EXC_EN
        ,
        S_EXC       = 5'd14
`endif
    } state_t;

    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       ab_write;
        logic       alu_out_write;
        logic       mdr_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       branch_ne;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    localparam logic [2:0] WAIT_LAST = MEM_WAIT[2:0];

`ifdef OVERFLOW_EXC_EN
    localparam state_t S_TRAP = S_EXC;
`else
    localparam state_t S_TRAP = S_FETCH;
`endif

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       last_s;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    logic       unused_inputs_s;

    function automatic logic funct_legal(input logic [5:0] fn);
        logic ok;
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] funct_alu_op(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_PASS;
        endcase
        return op;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t st, input logic last,
                                          input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read = 1'b1;
                if (last) begin
                    c.ir_write  = 1'b1;
                    c.alu_src_b = 2'b01;
                    c.alu_op    = ALU_ADD;
                    c.pc_write  = 1'b1;
                end else begin
                    c.ir_write  = 1'b0;
                end
            end
            S_DECODE: begin
                c.ab_write      = 1'b1;
                c.alu_src_b     = 2'b11;
                c.alu_op        = ALU_ADD;
                c.alu_out_write = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a     = 2'b01;
                c.alu_op        = funct_alu_op(fn);
                c.alu_out_write = 1'b1;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                c.alu_src_a     = 2'b01;
                c.alu_src_b     = 2'b10;
                c.alu_op        = ALU_ADD;
                c.alu_out_write = 1'b1;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_I_WB:   c.reg_write = 1'b1;
            S_MEM_READ: begin
                c.iord      = 1'b1;
                c.mem_read  = 1'b1;
                c.mdr_write = last;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 2'b01;
                c.alu_op        = ALU_SUB;
                c.pc_source     = 2'b01;
                c.pc_write_cond = 1'b1;
                c.branch_ne     = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_JR: begin
                c.alu_src_a = 2'b01;
                c.pc_write  = 1'b1;
            end
`ifdef OVERFLOW_EXC_EN
            S_EXC: begin
                c.pc_source = 2'b11;
                c.pc_write  = 1'b1;
            end
`endif
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Next-state and wait-counter logic; the counter only runs in memory-access states
    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        last_s  = (cnt_q == WAIT_LAST);
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
                if (!last_s) begin
                    cnt_d = cnt_q + 3'd1;
                end else if (state_q == S_FETCH) begin
                    state_d = S_DECODE;
                end else if (state_q == S_MEM_READ) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE:      state_d = (FUNCT == FN_JR) ? S_JR : S_R_EXEC;
                    OP_ADDI:       state_d = S_ADDI_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_R_EXEC: begin
                if (!funct_legal(FUNCT)) begin
                    state_d = S_TRAP;
`ifdef OVERFLOW_EXC_EN
                end else if (Overflow && ((FUNCT == FN_ADD) || (FUNCT == FN_SUB))) begin
                    state_d = S_EXC;
`endif
                end else begin
                    state_d = S_R_WB;
                end
            end
`ifdef OVERFLOW_EXC_EN
            S_ADDI_EXEC: state_d = Overflow ? S_EXC : S_I_WB;
`else
            S_ADDI_EXEC: state_d = S_I_WB;
`endif
            S_MEM_ADDR: begin
                if (OPCODE == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (OPCODE == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register alongside it
    always_comb begin
        ctrl_d = decode_ctrl(state_d, (cnt_d == WAIT_LAST), OPCODE, FUNCT);
    end

    // State, wait counter and control output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            cnt_q   <= 3'd0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

`ifdef OVERFLOW_EXC_EN
    logic epc_write_q;

    // EPC capture strobe, active only in the trap state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_write_q <= 1'b0;
        end else begin
            epc_write_q <= (state_d == S_EXC);
        end
    end

    assign EPCWrite = epc_write_q;
`else
    assign EPCWrite = 1'b0;
`endif

    // Zero qualifies PCWriteCond inside the datapath, so it is not consumed here
    assign unused_inputs_s = ^{Zero, Overflow};

    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign IRWrite     = ctrl_q.ir_write;
    assign ABWrite     = ctrl_q.ab_write;
    assign ALUOutWrite = ctrl_q.alu_out_write;
    assign MDRWrite    = ctrl_q.mdr_write;
    assign RegWrite    = ctrl_q.reg_write;
    assign RegDst      = ctrl_q.reg_dst;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign BranchNE    = ctrl_q.branch_ne;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: three instances with MEM_WAIT = 0, 2, 3, directed instruction vectors.
module tb_mc_control_unit;

    localparam logic [13:0] PCW  = 14'h2000;
    localparam logic [13:0] PCWC = 14'h1000;
    localparam logic [13:0] IORD = 14'h0800;
    localparam logic [13:0] MRD  = 14'h0400;
    localparam logic [13:0] MWR  = 14'h0200;
    localparam logic [13:0] IRW  = 14'h0100;
    localparam logic [13:0] ABW  = 14'h0080;
    localparam logic [13:0] AOW  = 14'h0040;
    localparam logic [13:0] MDRW = 14'h0020;
    localparam logic [13:0] RGW  = 14'h0010;
    localparam logic [13:0] RDST = 14'h0008;
    localparam logic [13:0] M2R  = 14'h0004;
    localparam logic [13:0] EPCW = 14'h0002;
    localparam logic [13:0] BNE  = 14'h0001;
    localparam logic [13:0] NONE = 14'h0000;

    logic        clk;
    logic        rst_n    [3];
    logic [5:0]  opc      [3];
    logic [5:0]  fn       [3];
    logic        zero     [3];
    logic        ovf      [3];
    logic [1:0]  src_a    [3];
    logic [1:0]  src_b    [3];
    logic [2:0]  alu_op   [3];
    logic [1:0]  pc_src   [3];
    logic        pc_wr    [3];
    logic        pc_wr_c  [3];
    logic        iord     [3];
    logic        mem_rd   [3];
    logic        mem_wr   [3];
    logic        ir_wr    [3];
    logic        ab_wr    [3];
    logic        aout_wr  [3];
    logic        mdr_wr   [3];
    logic        reg_wr   [3];
    logic        reg_dst  [3];
    logic        m2r      [3];
    logic        epc_wr   [3];
    logic        br_ne    [3];
    logic [4:0]  st_dbg   [3];
    logic [27:0] obs      [3];

    int          idx_q  [$];
    logic [27:0] exp_q  [$];
    string       name_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] op_tab [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_control_unit #(.MEM_WAIT((g == 0) ? 0 : g + 1)) u_dut (
            .clk(clk), .reset(rst_n[g]), .OPCODE(opc[g]), .FUNCT(fn[g]),
            .Zero(zero[g]), .Overflow(ovf[g]),
            .ALUSrcA(src_a[g]), .ALUSrcB(src_b[g]), .ALUOp(alu_op[g]), .PCSource(pc_src[g]),
            .PCWrite(pc_wr[g]), .PCWriteCond(pc_wr_c[g]), .IorD(iord[g]), .MemRead(mem_rd[g]),
            .MemWrite(mem_wr[g]), .IRWrite(ir_wr[g]), .ABWrite(ab_wr[g]), .ALUOutWrite(aout_wr[g]),
            .MDRWrite(mdr_wr[g]), .RegWrite(reg_wr[g]), .RegDst(reg_dst[g]), .MemtoReg(m2r[g]),
            .EPCWrite(epc_wr[g]), .BranchNE(br_ne[g]), .state_dbg(st_dbg[g])
        );
        assign obs[g] = {st_dbg[g], src_a[g], src_b[g], alu_op[g], pc_src[g],
                         pc_wr[g], pc_wr_c[g], iord[g], mem_rd[g], mem_wr[g], ir_wr[g], ab_wr[g],
                         aout_wr[g], mdr_wr[g], reg_wr[g], reg_dst[g], m2r[g], epc_wr[g], br_ne[g]};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [27:0] ev(input logic [4:0] st, input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] op, input logic [1:0] pcs, input logic [13:0] s);
        return {st, a, b, op, pcs, s};
    endfunction

    // Scoreboard monitor: one expectation consumed per falling edge
    always @(negedge clk) begin : mon
        int          k;
        logic [27:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            k  = idx_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (obs[k] === e) n_pass++;
            else $display("FAIL %s (dut%0d): got %h, expected %h", nm, k, obs[k], e);
        end
    end

    task automatic cyc(input int k, input string nm, input logic [27:0] v);
        idx_q.push_back(k);
        exp_q.push_back(v);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int k, input logic [5:0] o, input logic [5:0] f, input logic z, input logic v);
        opc[k]  = o;
        fn[k]   = f;
        zero[k] = z;
        ovf[k]  = v;
    endtask

    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        #1;
        n_checks++;
        if (obs[k] === 28'd0) n_pass++;
        else $display("FAIL reset_async (dut%0d): got %h, expected %h", k, obs[k], 28'd0);
        for (int i = 0; i < 3; i++) cyc(k, "reset_held", ev(5'd0, 2'b00, 2'b00, 3'b000, 2'b00, NONE));
        rst_n[k] = 1'b1;
        cyc(k, "reset_released", ev(5'd0, 2'b00, 2'b00, 3'b000, 2'b00, NONE));
    endtask

    task automatic fetch_dec(input int k, input int w);
        for (int i = 0; i < w; i++) cyc(k, "fetch_wait", ev(5'd1, 2'b00, 2'b00, 3'b000, 2'b00, MRD));
        cyc(k, "fetch_last", ev(5'd1, 2'b00, 2'b01, 3'b001, 2'b00, MRD | IRW | PCW));
        cyc(k, "decode", ev(5'd2, 2'b00, 2'b11, 3'b001, 2'b00, ABW | AOW));
    endtask

    task automatic trap(input int k);
`ifdef OVERFLOW_EXC_EN
        cyc(k, "exc", ev(5'd14, 2'b00, 2'b00, 3'b000, 2'b11, PCW | EPCW));
`else
        if (k < 0) $display("unreachable trap index %0d", k);
`endif
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b1;
            set_in(i, 6'h00, 6'h00, 1'b0, 1'b0);
        end
        #2;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
        @(posedge clk);
        #1;

        // MEM_WAIT = 0 instance: every instruction class
        do_reset(0);
        for (int i = 0; i < 5; i++) begin
            set_in(0, 6'h00, fn_tab[i], 1'b0, 1'b0);
            fetch_dec(0, 0);
            cyc(0, "r_exec", ev(5'd3, 2'b01, 2'b00, op_tab[i], 2'b00, AOW));
            cyc(0, "r_wb", ev(5'd4, 2'b00, 2'b00, 3'b000, 2'b00, RGW | RDST));
        end
        set_in(0, 6'h00, 6'h24, 1'b0, 1'b1);
        fetch_dec(0, 0);
        cyc(0, "and_ovf_exec", ev(5'd3, 2'b01, 2'b00, 3'b011, 2'b00, AOW));
        cyc(0, "and_ovf_wb", ev(5'd4, 2'b00, 2'b00, 3'b000, 2'b00, RGW | RDST));
        set_in(0, 6'h00, 6'h22, 1'b0, 1'b1);
        fetch_dec(0, 0);
        cyc(0, "sub_ovf_exec", ev(5'd3, 2'b01, 2'b00, 3'b010, 2'b00, AOW));
`ifdef OVERFLOW_EXC_EN
        trap(0);
`else
        cyc(0, "sub_ovf_wb", ev(5'd4, 2'b00, 2'b00, 3'b000, 2'b00, RGW | RDST));
`endif
        set_in(0, 6'h08, 6'h00, 1'b0, 1'b1);
        fetch_dec(0, 0);
        cyc(0, "addi_ovf_exec", ev(5'd5, 2'b01, 2'b10, 3'b001, 2'b00, AOW));
`ifdef OVERFLOW_EXC_EN
        trap(0);
`else
        cyc(0, "addi_ovf_wb", ev(5'd6, 2'b00, 2'b00, 3'b000, 2'b00, RGW));
`endif
        set_in(0, 6'h08, 6'h00, 1'b0, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "addi_exec", ev(5'd5, 2'b01, 2'b10, 3'b001, 2'b00, AOW));
        cyc(0, "addi_wb", ev(5'd6, 2'b00, 2'b00, 3'b000, 2'b00, RGW));
        set_in(0, 6'h00, 6'h00, 1'b0, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "bad_funct_exec", ev(5'd3, 2'b01, 2'b00, 3'b000, 2'b00, AOW));
        trap(0);
        set_in(0, 6'h3F, 6'h00, 1'b0, 1'b0);
        fetch_dec(0, 0);
        trap(0);
        set_in(0, 6'h00, 6'h08, 1'b0, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "jr", ev(5'd13, 2'b01, 2'b00, 3'b000, 2'b00, PCW));
        set_in(0, 6'h02, 6'h00, 1'b0, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "jump", ev(5'd12, 2'b00, 2'b00, 3'b000, 2'b10, PCW));
        set_in(0, 6'h04, 6'h00, 1'b1, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "beq", ev(5'd11, 2'b01, 2'b00, 3'b010, 2'b01, PCWC));
        set_in(0, 6'h05, 6'h00, 1'b1, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "bne_zero1", ev(5'd11, 2'b01, 2'b00, 3'b010, 2'b01, PCWC | BNE));
        set_in(0, 6'h05, 6'h00, 1'b0, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "bne_zero0", ev(5'd11, 2'b01, 2'b00, 3'b010, 2'b01, PCWC | BNE));
        set_in(0, 6'h2B, 6'h00, 1'b0, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "sw_addr", ev(5'd7, 2'b01, 2'b10, 3'b001, 2'b00, AOW));
        cyc(0, "sw_write", ev(5'd10, 2'b00, 2'b00, 3'b000, 2'b00, IORD | MWR));
        set_in(0, 6'h23, 6'h00, 1'b0, 1'b0);
        fetch_dec(0, 0);
        cyc(0, "lw_addr", ev(5'd7, 2'b01, 2'b10, 3'b001, 2'b00, AOW));
        cyc(0, "lw_read", ev(5'd8, 2'b00, 2'b00, 3'b000, 2'b00, IORD | MRD | MDRW));
        cyc(0, "lw_wb", ev(5'd9, 2'b00, 2'b00, 3'b000, 2'b00, RGW | M2R));
        set_in(0, 6'h00, 6'h20, 1'b0, 1'b0);
        cyc(0, "refetch", ev(5'd1, 2'b00, 2'b01, 3'b001, 2'b00, MRD | IRW | PCW));
        rst_n[0] = 1'b0;

        // MEM_WAIT = 2 instance: lw spans 9 cycles
        do_reset(1);
        set_in(1, 6'h23, 6'h00, 1'b0, 1'b0);
        fetch_dec(1, 2);
        cyc(1, "lw_addr", ev(5'd7, 2'b01, 2'b10, 3'b001, 2'b00, AOW));
        for (int i = 0; i < 2; i++) cyc(1, "lw_read_wait", ev(5'd8, 2'b00, 2'b00, 3'b000, 2'b00, IORD | MRD));
        cyc(1, "lw_read_last", ev(5'd8, 2'b00, 2'b00, 3'b000, 2'b00, IORD | MRD | MDRW));
        cyc(1, "lw_wb", ev(5'd9, 2'b00, 2'b00, 3'b000, 2'b00, RGW | M2R));
        cyc(1, "refetch_wait", ev(5'd1, 2'b00, 2'b00, 3'b000, 2'b00, MRD));
        rst_n[1] = 1'b0;

        // MEM_WAIT = 3 instance: reset lands in the second MEM_WRITE cycle
        do_reset(2);
        set_in(2, 6'h2B, 6'h00, 1'b0, 1'b0);
        fetch_dec(2, 3);
        cyc(2, "sw_addr", ev(5'd7, 2'b01, 2'b10, 3'b001, 2'b00, AOW));
        cyc(2, "sw_write_c1", ev(5'd10, 2'b00, 2'b00, 3'b000, 2'b00, IORD | MWR));
        do_reset(2);
        cyc(2, "fetch_after_abort", ev(5'd1, 2'b00, 2'b00, 3'b000, 2'b00, MRD));

        @(posedge clk);
        #1;
        if ((n_pass != n_checks) || (exp_q.size() != 0))
            $display("FAIL summary: %0d of %0d checks passed, %0d expectations pending", n_pass, n_checks, exp_q.size());
        else
            $display("PASS all checks");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
